// File: rtl/rf_scan_pkg.sv
// Shared types and widths for the register-file scan reader.
package rf_scan_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned CNT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rf_scan_reader_piso_32.sv
// 32-bit parallel-in/serial-out shift register, MSB first; load beats shift.
module piso_32
  import rf_scan_pkg::*;
(
  input  logic              clk,
  input  logic              arst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              msb
);

  logic [DATA_W-1:0] shreg;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= {shreg[DATA_W-2:0], 1'b0};
    end
  end

  assign msb = shreg[DATA_W-1];

endmodule

// File: rtl/rf_scan_reader.sv
// Debug read-back engine: walks a register-file address range and streams
// each word MSB-first over a valid/ready bit interface.
module rf_scan_reader
  import rf_scan_pkg::*;
(
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              sout,
  output logic              sout_valid,
  input  logic              sout_ready,
  output logic              frame,
  output logic              busy,
  output logic              done
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic              load_c;
  logic              shift_c;

  piso_32 u_piso (
    .clk    (clk),
    .arst_n (arst_n),
    .load   (load_c),
    .shift  (shift_c),
    .din    (rf_rdata),
    .msb    (sout)
  );

  // rf_raddr doubles as the scan address register so it is stable in every state
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= IDLE;
      rf_raddr   <= '0;
      last_q     <= '0;
      bitcnt_q   <= '0;
      sout_valid <= 1'b0;
      frame      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rf_raddr   <= addr_d;
      last_q     <= last_d;
      bitcnt_q   <= bitcnt_d;
      sout_valid <= (state_d == SHIFT);
      frame      <= (state_d == SHIFT) && (bitcnt_d == '0);
      busy       <= (state_d != IDLE);
      done       <= (state_d == DONE);
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = rf_raddr;
    last_d   = last_q;
    bitcnt_d = bitcnt_q;
    load_c   = 1'b0;
    shift_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = first_addr;
          last_d  = last_addr;
          state_d = FETCH;
        end
      end
      FETCH: begin
        load_c   = 1'b1;
        bitcnt_d = '0;
        state_d  = SHIFT;
      end
      SHIFT: begin
        if (sout_valid && sout_ready) begin
          shift_c  = 1'b1;
          bitcnt_d = bitcnt_q + CNT_W'(1);
          if (bitcnt_q == CNT_W'(DATA_W - 1)) begin
            if (rf_raddr == last_q) begin
              state_d = DONE;
            end else begin
              // address wraps naturally at NREGS
              addr_d  = rf_raddr + ADDR_W'(1);
              state_d = FETCH;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rf_scan_reader.sv
// Directed self-checking bench for rf_scan_reader.
module tb_rf_scan_reader;

  logic        clk;
  logic        arst_n;
  logic        start;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        sout;
  logic        sout_valid;
  logic        sout_ready;
  logic        frame;
  logic        busy;
  logic        done;

  logic [31:0] rf [32];
  assign rf_rdata = rf[rf_raddr];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [31:0] cap_words[$];
  logic [4:0]  cap_addrs[$];

  rf_scan_reader dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .rf_raddr   (rf_raddr),
    .rf_rdata   (rf_rdata),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_ready (sout_ready),
    .frame      (frame),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one scan and collects the stream; callers do the comparisons.
  task automatic run_scan(input logic [4:0] f, input logic [4:0] l, input bit rnd_ready,
                          input int inj_cyc, output int first_valid, output int done_cyc,
                          output int done_cnt, output int unstable, output int frame_err,
                          output bit timeout);
    int          cyc;
    int          bitidx;
    logic [31:0] cur;
    bit          prev_hold;
    logic        prev_sout;
    logic        prev_frame;
    cap_words.delete();
    cap_addrs.delete();
    first_valid = -1; done_cyc = -1; done_cnt = 0; unstable = 0; frame_err = 0;
    timeout = 1'b0; bitidx = 0; cur = '0; prev_hold = 1'b0; prev_sout = 1'b0; prev_frame = 1'b0;
    @(negedge clk);
    first_addr = f; last_addr = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc <= 3000) begin
      if (prev_hold && (sout !== prev_sout || frame !== prev_frame || sout_valid !== 1'b1))
        unstable++;
      if (sout_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (cyc == inj_cyc) begin
        start = 1'b1; first_addr = 5'd3; last_addr = 5'd3;
      end else begin
        start = 1'b0;
      end
      sout_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
      if (sout_valid === 1'b1 && sout_ready) begin
        if (frame !== (bitidx == 0)) frame_err++;
        if (bitidx == 0) cap_addrs.push_back(rf_raddr);
        cur = {cur[30:0], sout};
        bitidx++;
        if (bitidx == 32) begin
          cap_words.push_back(cur);
          bitidx = 0;
        end
      end
      prev_hold  = (sout_valid === 1'b1) && !sout_ready;
      prev_sout  = sout;
      prev_frame = frame;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      @(posedge clk); #1;
      cyc++;
    end
    if (done_cyc < 0) timeout = 1'b1;
    start = 1'b0;
    sout_ready = 1'b1;
  endtask

  task automatic test_reset();
    int bad;
    arst_n = 1'b0; start = 1'b0; sout_ready = 1'b1; first_addr = '0; last_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++; if (rf_raddr !== 5'd0) $display("FAIL reset_raddr got %h want 0", rf_raddr); else pass_cnt++;
    chk_cnt++; if (sout !== 1'b0) $display("FAIL reset_sout got %b want 0", sout); else pass_cnt++;
    chk_cnt++; if (sout_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", sout_valid); else pass_cnt++;
    chk_cnt++; if (frame !== 1'b0) $display("FAIL reset_frame got %b want 0", frame); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
    @(negedge clk);
    arst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if ({rf_raddr, sout, sout_valid, frame, busy, done} !== 10'd0) bad++;
    end
    chk_cnt++; if (bad != 0) $display("FAIL idle_hold got %0d nonzero cycles want 0", bad); else pass_cnt++;
  endtask

  task automatic test_single_word();
    int fv, dc, dn, us, fe;
    bit to;
    rf[5] = 32'hA5A5_0F0F;
    run_scan(5'd5, 5'd5, 1'b0, -1, fv, dc, dn, us, fe, to);
    chk_cnt++; if (to) $display("FAIL single_timeout got no done want done"); else pass_cnt++;
    chk_cnt++; if (fv != 2) $display("FAIL single_first_valid got %0d want 2", fv); else pass_cnt++;
    chk_cnt++; if (dc != 34) $display("FAIL single_done_cycle got %0d want 34", dc); else pass_cnt++;
    chk_cnt++; if (dn != 1) $display("FAIL single_done_count got %0d want 1", dn); else pass_cnt++;
    chk_cnt++; if (fe != 0) $display("FAIL single_frame got %0d errors want 0", fe); else pass_cnt++;
    chk_cnt++;
    if (cap_words.size() != 1 || cap_words[0] !== 32'hA5A5_0F0F)
      $display("FAIL single_word got %0d words first %h want 1 word a5a50f0f",
               cap_words.size(), (cap_words.size() > 0) ? cap_words[0] : 32'h0);
    else pass_cnt++;
  endtask

  task automatic test_full_range();
    int fv, dc, dn, us, fe, bad;
    bit to;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
    run_scan(5'd0, 5'd31, 1'b0, -1, fv, dc, dn, us, fe, to);
    chk_cnt++; if (dc != 32 * 33 + 1) $display("FAIL full_done_cycle got %0d want %0d", dc, 32 * 33 + 1); else pass_cnt++;
    chk_cnt++; if (cap_words.size() != 32) $display("FAIL full_count got %0d want 32", cap_words.size()); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (i >= cap_words.size() || cap_words[i] !== 32'h1000_0000 + i) bad++;
      if (i >= cap_addrs.size() || cap_addrs[i] !== 5'(i)) bad++;
    end
    chk_cnt++; if (bad != 0) $display("FAIL full_words_addrs got %0d mismatches want 0", bad); else pass_cnt++;
    chk_cnt++; if (fe != 0) $display("FAIL full_frame got %0d errors want 0", fe); else pass_cnt++;
  endtask

  task automatic test_back_pressure();
    int fv, dc, dn, us, fe;
    bit to;
    rf[12] = 32'hCAFE_1234;
    rf[13] = 32'h8000_0001;
    run_scan(5'd12, 5'd13, 1'b1, -1, fv, dc, dn, us, fe, to);
    chk_cnt++; if (to) $display("FAIL bp_timeout got no done want done"); else pass_cnt++;
    chk_cnt++; if (us != 0) $display("FAIL bp_stable got %0d changes while stalled want 0", us); else pass_cnt++;
    chk_cnt++; if (fe != 0) $display("FAIL bp_frame got %0d errors want 0", fe); else pass_cnt++;
    chk_cnt++;
    if (cap_words.size() != 2 || cap_words[0] !== 32'hCAFE_1234 || cap_words[1] !== 32'h8000_0001)
      $display("FAIL bp_words got %0d words want cafe1234 80000001", cap_words.size());
    else pass_cnt++;
    chk_cnt++; if (dn != 1) $display("FAIL bp_done_count got %0d want 1", dn); else pass_cnt++;
  endtask

  task automatic test_wrap_ignored_start();
    int fv, dc, dn, us, fe;
    bit to;
    for (int i = 0; i < 32; i++) rf[i] = 32'h5A00_0000 + (i << 8) + i;
    run_scan(5'd30, 5'd1, 1'b0, 40, fv, dc, dn, us, fe, to);
    chk_cnt++;
    if (cap_addrs.size() != 4 || cap_addrs[0] !== 5'd30 || cap_addrs[1] !== 5'd31 ||
        cap_addrs[2] !== 5'd0 || cap_addrs[3] !== 5'd1)
      $display("FAIL wrap_addrs got %0d words want order 30 31 0 1", cap_addrs.size());
    else pass_cnt++;
    chk_cnt++;
    if (cap_words.size() != 4 || cap_words[0] !== rf[30] || cap_words[1] !== rf[31] ||
        cap_words[2] !== rf[0] || cap_words[3] !== rf[1])
      $display("FAIL wrap_words got %0d words want rf[30] rf[31] rf[0] rf[1]", cap_words.size());
    else pass_cnt++;
    chk_cnt++; if (dc != 4 * 33 + 1) $display("FAIL wrap_done_cycle got %0d want %0d", dc, 4 * 33 + 1); else pass_cnt++;
    chk_cnt++; if (dn != 1) $display("FAIL wrap_done_count got %0d want 1", dn); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int accepted, cyc, done_seen, fv, dc, dn, us, fe;
    bit to, hit;
    @(negedge clk);
    first_addr = 5'd0; last_addr = 5'd3; start = 1'b1; sout_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    accepted = 0; cyc = 0; done_seen = 0; hit = 1'b0;
    while (cyc < 300) begin
      if (done === 1'b1) done_seen++;
      if (accepted == 32 + 17) begin
        hit = 1'b1;
        break;
      end
      if (sout_valid === 1'b1) accepted++;
      @(posedge clk); #1;
      cyc++;
    end
    chk_cnt++; if (!hit) $display("FAIL midrst_reach got %0d bits want 49", accepted); else pass_cnt++;
    #1 arst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({rf_raddr, sout, sout_valid, frame, busy, done} !== 10'd0)
      $display("FAIL midrst_async got %b want 0", {rf_raddr, sout, sout_valid, frame, busy, done});
    else pass_cnt++;
    repeat (2) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
    end
    @(negedge clk);
    arst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    chk_cnt++; if (done_seen != 0) $display("FAIL midrst_no_done got %0d done/busy cycles want 0", done_seen); else pass_cnt++;
    rf[7] = 32'h0123_4567;
    run_scan(5'd7, 5'd7, 1'b0, -1, fv, dc, dn, us, fe, to);
    chk_cnt++;
    if (to || dc != 34 || cap_words.size() != 1 || cap_words[0] !== 32'h0123_4567)
      $display("FAIL midrst_restart got done_cycle %0d words %0d want 34 and 01234567", dc, cap_words.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full_range();
    test_back_pressure();
    test_wrap_ignored_start();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
